// File: rtl/uart_io_ctrl_pkg.sv
// Shared types and helpers for the UART request responder: engine state encodings,
// byte-count constants and the byte-lane placement helper.
package uart_io_ctrl_pkg;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_SEND = 2'd1,
        T_DONE = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE    = 2'd0,
        R_COLLECT = 2'd1,
        R_DONE    = 2'd2
    } rx_state_t;

    // Request size fields carry "byte count minus one"
    localparam logic [1:0] IO_SZ_1 = 2'd0;
    localparam logic [1:0] IO_SZ_2 = 2'd1;
    localparam logic [1:0] IO_SZ_3 = 2'd2;
    localparam logic [1:0] IO_SZ_4 = 2'd3;

    function automatic logic [31:0] byte_lane(input logic [7:0] data, input logic [1:0] lane);
        byte_lane = 32'(data) << {lane, 3'b000};
    endfunction

endpackage

// File: rtl/uart_io_ctrl_rx_fifo.sv
// Byte-wide synchronous FIFO buffering received UART bytes until an IN request drains them.
module uart_rx_fifo #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    logic [7:0]  mem [2**AW];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_push;
    logic        do_pop;

    // Extra pointer bit distinguishes full from empty when the low bits match
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_io_ctrl.sv
// Responder for exec-stage UART OUT/IN requests: splits OUT words into bytes for the
// transmitter and packs buffered received bytes into IN words, little-endian.
module uart_io_ctrl
    import uart_io_ctrl_pkg::*;
#(
    parameter int RXF_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_wenable,
    input  logic [1:0]  uart_wsz,
    input  logic [31:0] uart_wd,
    output logic        uart_wdone,
    input  logic        uart_renable,
    input  logic [1:0]  uart_rsz,
    output logic [31:0] uart_rd,
    output logic        uart_rdone,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_overrun
);

    tx_state_t   tx_state;
    tx_state_t   tx_next;
    logic [31:0] tx_word;
    logic [1:0]  tx_cnt;

    rx_state_t   rx_state;
    rx_state_t   rx_next;
    logic [31:0] rx_asm;
    logic [31:0] rx_asm_next;
    logic [1:0]  rx_cnt;
    logic [1:0]  rx_sz;
    logic [1:0]  rx_idx;
    logic [31:0] rd_q;
    logic        rx_pop;

    logic [7:0]  fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;

    uart_rx_fifo #(.AW(RXF_AW)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .pop   (rx_pop),
        .wdata (rx_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) tx_state <= T_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next    = tx_state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        uart_wdone = 1'b0;
        case (tx_state)
            T_IDLE: if (uart_wenable) tx_next = T_SEND;
            T_SEND: begin
                tx_valid = 1'b1;
                tx_data  = tx_word[7:0];
                if (tx_ready && tx_cnt == IO_SZ_1) tx_next = T_DONE;
            end
            T_DONE: begin
                uart_wdone = 1'b1;
                tx_next    = T_IDLE;
            end
            default: tx_next = T_IDLE;
        endcase
    end

    // Low byte is always the one on the wire; shift down after each accepted byte
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_word <= '0;
            tx_cnt  <= '0;
        end else if (tx_state == T_IDLE && uart_wenable) begin
            tx_word <= uart_wd;
            tx_cnt  <= uart_wsz;
        end else if (tx_state == T_SEND && tx_ready) begin
            tx_word <= {8'h00, tx_word[31:8]};
            tx_cnt  <= tx_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rx_state <= R_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next    = rx_state;
        rx_pop     = 1'b0;
        uart_rdone = 1'b0;
        case (rx_state)
            R_IDLE: if (uart_renable) rx_next = R_COLLECT;
            R_COLLECT: begin
                if (!fifo_empty) begin
                    rx_pop = 1'b1;
                    if (rx_cnt == IO_SZ_1) rx_next = R_DONE;
                end
            end
            R_DONE: begin
                uart_rdone = 1'b1;
                rx_next    = R_IDLE;
            end
            default: rx_next = R_IDLE;
        endcase
    end

    assign rx_idx      = rx_sz - rx_cnt;
    assign rx_asm_next = rx_asm | byte_lane(fifo_rdata, rx_idx);

    // Result register is loaded on the last pop so it is valid alongside rdone
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_asm     <= '0;
            rx_cnt     <= '0;
            rx_sz      <= '0;
            rd_q       <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_state == R_IDLE && uart_renable) begin
                rx_asm <= '0;
                rx_cnt <= uart_rsz;
                rx_sz  <= uart_rsz;
            end else if (rx_pop) begin
                rx_asm <= rx_asm_next;
                rx_cnt <= rx_cnt - 1'b1;
                if (rx_cnt == IO_SZ_1) rd_q <= rx_asm_next;
            end
            if (rx_valid && fifo_full && !rx_pop) rx_overrun <= 1'b1;
        end
    end

    assign uart_rd = rd_q;

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Self-checking bench for uart_io_ctrl: vector table for single requests, hand-written
// sequences for stalls, FIFO overflow, concurrent engines and reset abort.
module tb_uart_io_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_wenable = 1'b0;
    logic [1:0]  uart_wsz = 2'd0;
    logic [31:0] uart_wd = 32'h0;
    logic        uart_wdone;
    logic        uart_renable = 1'b0;
    logic [1:0]  uart_rsz = 2'd0;
    logic [31:0] uart_rd;
    logic        uart_rdone;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_overrun;

    int errors = 0;
    int checks = 0;
    int wdone_seen = 0;
    int rdone_seen = 0;
    bit tx_busy = 1'b0;
    bit rx_busy = 1'b0;
    logic [7:0]  tx_q[$];
    logic [31:0] rd_q[$];

    typedef struct {
        bit          is_out;
        logic [1:0]  sz;
        logic [31:0] data;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    uart_io_ctrl #(.RXF_AW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_wenable (uart_wenable),
        .uart_wsz     (uart_wsz),
        .uart_wd      (uart_wd),
        .uart_wdone   (uart_wdone),
        .uart_renable (uart_renable),
        .uart_rsz     (uart_rsz),
        .uart_rd      (uart_rd),
        .uart_rdone   (uart_rdone),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard side: accepted bytes and IN results are compared against queued expectations
    always @(negedge clk) begin
        if (rst) begin
            tx_busy = 1'b0;
            rx_busy = 1'b0;
        end else begin
            if (uart_wenable) begin
                checkOutput("wenable_while_busy", 32'(tx_busy), 32'd0);
                tx_busy = 1'b1;
            end
            if (uart_renable) begin
                checkOutput("renable_while_busy", 32'(rx_busy), 32'd0);
                rx_busy = 1'b1;
            end
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) checkOutput("tx_unexpected_byte", 32'(tx_data), 32'hxxxxxxxx);
                else checkOutput("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
            end
            if (uart_wdone) begin
                wdone_seen++;
                tx_busy = 1'b0;
            end
            if (uart_rdone) begin
                rdone_seen++;
                rx_busy = 1'b0;
                if (rd_q.size() == 0) checkOutput("rd_unexpected", uart_rd, 32'hxxxxxxxx);
                else checkOutput("rd_word", uart_rd, rd_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input bit we, input logic [1:0] wsz, input logic [31:0] wd,
                                 input bit re, input logic [1:0] rsz);
        @(posedge clk); #1;
        uart_wenable = we;
        uart_wsz     = wsz;
        uart_wd      = wd;
        uart_renable = re;
        uart_rsz     = rsz;
        @(posedge clk); #1;
        uart_wenable = 1'b0;
        uart_renable = 1'b0;
    endtask

    task automatic pushBurst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b1;
            rx_data  = first + 8'(i);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic waitDone(input bit is_w, input int budget, output int cyc);
        cyc = 1;
        while (!(is_w ? uart_wdone : uart_rdone) && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!(is_w ? uart_wdone : uart_rdone))
            checkOutput(is_w ? "wdone_timeout" : "rdone_timeout", 32'd0, 32'd1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tx_q.delete();
        rd_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        int base;

        vecs[0] = '{1'b1, 2'd3, 32'h44332211, 32'h44332211, 5};
        vecs[1] = '{1'b1, 2'd1, 32'hFFFFBEEF, 32'h0000BEEF, 3};
        vecs[2] = '{1'b1, 2'd2, 32'h00C0FFEE, 32'h00C0FFEE, 4};
        vecs[3] = '{1'b1, 2'd0, 32'h9988775A, 32'h0000005A, 2};
        vecs[4] = '{1'b0, 2'd3, 32'h0A0B0C0D, 32'h0A0B0C0D, 5};
        vecs[5] = '{1'b0, 2'd1, 32'h0000017F, 32'h0000017F, 3};
        vecs[6] = '{1'b0, 2'd2, 32'h00112233, 32'h00112233, 4};
        vecs[7] = '{1'b0, 2'd0, 32'h000000C3, 32'h000000C3, 2};

        doReset();
        checkOutput("rst_wdone", 32'(uart_wdone), 32'd0);
        checkOutput("rst_rdone", 32'(uart_rdone), 32'd0);
        checkOutput("rst_rd", uart_rd, 32'd0);
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_overrun", 32'(rx_overrun), 32'd0);

        foreach (vecs[v]) begin
            if (vecs[v].is_out) begin
                for (int b = 0; b <= int'(vecs[v].sz); b++) tx_q.push_back(vecs[v].exp[8*b +: 8]);
                applyStimulus(1'b1, vecs[v].sz, vecs[v].data, 1'b0, 2'd0);
            end else begin
                for (int b = 0; b <= int'(vecs[v].sz); b++) pushBurst(vecs[v].data[8*b +: 8], 1);
                rd_q.push_back(vecs[v].exp);
                applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, vecs[v].sz);
            end
            waitDone(vecs[v].is_out, 50, cyc);
            checkOutput($sformatf("vec%0d_latency", v), 32'(cyc), 32'(vecs[v].lat));
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d_single_pulse", v),
                        32'(vecs[v].is_out ? uart_wdone : uart_rdone), 32'd0);
            checkOutput($sformatf("vec%0d_queue_drained", v), 32'(tx_q.size() + rd_q.size()), 32'd0);
        end
        repeat (3) @(posedge clk);
        #1 checkOutput("rd_hold", uart_rd, 32'h000000C3);

        // Transmitter stalled: byte must be presented unchanged until accepted
        tx_ready = 1'b0;
        tx_q.push_back(8'hA5);
        applyStimulus(1'b1, 2'd0, 32'h000000A5, 1'b0, 2'd0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_tx_valid", 32'(tx_valid), 32'd1);
            checkOutput("stall_tx_data", 32'(tx_data), 32'hA5);
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("stall_wdone_after_accept", 32'(uart_wdone), 32'd1);
        @(posedge clk); #1;
        checkOutput("stall_wdone_single", 32'(uart_wdone), 32'd0);

        // IN request waiting on an empty FIFO
        base = rdone_seen;
        rd_q.push_back(32'h00006655);
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
        pushBurst(8'h55, 1);
        repeat (20) @(posedge clk);
        #1 checkOutput("rdone_early", 32'(rdone_seen - base), 32'd0);
        pushBurst(8'h66, 1);
        waitDone(1'b0, 20, cyc);
        @(posedge clk); #1;
        checkOutput("wait_rdone_count", 32'(rdone_seen - base), 32'd1);

        // Overflow: 17th byte is dropped
        pushBurst(8'h00, 16);
        checkOutput("full_no_overrun", 32'(rx_overrun), 32'd0);
        pushBurst(8'h10, 1);
        checkOutput("overrun_set", 32'(rx_overrun), 32'd1);
        for (int r = 0; r < 4; r++) begin
            rd_q.push_back({8'(4*r+3), 8'(4*r+2), 8'(4*r+1), 8'(4*r)});
            applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 2'd3);
            waitDone(1'b0, 50, cyc);
        end
        @(posedge clk); #1;
        checkOutput("overflow_reads_drained", 32'(rd_q.size()), 32'd0);

        // Full FIFO with a pop in the same cycle accepts the push
        doReset();
        pushBurst(8'h00, 16);
        rd_q.push_back(32'h00000000);
        @(posedge clk); #1;
        uart_renable = 1'b1;
        uart_rsz     = 2'd0;
        @(posedge clk); #1;
        uart_renable = 1'b0;
        rx_valid     = 1'b1;
        rx_data      = 8'h99;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        checkOutput("pop_push_full_no_overrun", 32'(rx_overrun), 32'd0);
        waitDone(1'b0, 10, cyc);
        rd_q.push_back(32'h04030201);
        rd_q.push_back(32'h08070605);
        rd_q.push_back(32'h0C0B0A09);
        rd_q.push_back(32'h990F0E0D);
        for (int r = 0; r < 4; r++) begin
            @(posedge clk); #1;
            applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 2'd3);
            waitDone(1'b0, 50, cyc);
        end
        @(posedge clk); #1;
        checkOutput("pop_push_reads_drained", 32'(rd_q.size()), 32'd0);
        checkOutput("pop_push_overrun_clear", 32'(rx_overrun), 32'd0);

        // Both engines started together
        doReset();
        pushBurst(8'h3C, 1);
        tx_q.push_back(8'h77);
        rd_q.push_back(32'h0000003C);
        applyStimulus(1'b1, 2'd0, 32'h00000077, 1'b1, 2'd0);
        @(posedge clk); #1;
        checkOutput("dual_wdone", 32'(uart_wdone), 32'd1);
        checkOutput("dual_rdone", 32'(uart_rdone), 32'd1);
        @(posedge clk); #1;
        checkOutput("dual_done_cleared", 32'({uart_wdone, uart_rdone}), 32'd0);

        // Reset in the middle of an OUT request aborts it silently
        tx_ready = 1'b0;
        applyStimulus(1'b1, 2'd3, 32'hDEADBEEF, 1'b0, 2'd0);
        @(posedge clk); #1;
        checkOutput("abort_tx_valid_before", 32'(tx_valid), 32'd1);
        base = wdone_seen;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("abort_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        tx_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 checkOutput("abort_no_wdone", 32'(wdone_seen - base), 32'd0);
        checkOutput("abort_tx_idle", 32'(tx_valid), 32'd0);
        checkOutput("final_queues_empty", 32'(tx_q.size() + rd_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
